hamming_secded_decoder: RTL

Parametrised, pipelined Hamming SECDED decoder for the RISC-V memory/bus protection path. It generalises our 38-bit single-error corrector in three ways: any data width, an added overall-parity bit for double-error detection, and a two-stage valid/ready pipeline. It also keeps saturating error-statistics counters. It sits between the protected storage read port and the core-side consumer.

---
 rtl/hamming_secded_decoder.sv | 106 ++++++++++
 1 files changed

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder: pipelined Hamming SECDED decoder with valid/ready flow and saturating error counters.
module hamming_secded_decoder #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  localparam int P0 = $clog2(DATA_W + 1),
  localparam int P1 = $clog2(DATA_W + P0 + 1),
  localparam int P2 = $clog2(DATA_W + P1 + 1),
  localparam int P = $clog2(DATA_W + P2 + 1),
  localparam int N = DATA_W + P,
  localparam int CW_W = N + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syndrome,
  output logic              out_corrected,
  output logic              out_uncorrectable,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);
  localparam logic [P-1:0] N_P = P'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, s1_pe_q, s1_pe_d;
  logic [CW_W-1:0] s1_cw_q, s1_cw_d;
  logic [P-1:0] s1_syn_q, s1_syn_d, s2_syn_q, s2_syn_d, syn;
  logic [DATA_W-1:0] s2_data_q, s2_data_d, data;
  logic s2_corr_q, s2_corr_d, s2_unc_q, s2_unc_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;
  logic [N-1:0] fixed;
  logic corr, unc, s1_ld, s2_ld, s2_en, out_hs;
  int k;
  always_comb begin
    syn = '0;
    for (int i = 0; i < P; i++)
      for (int j = 1; j <= N; j++)
        syn[i] = syn[i] ^ (in_cw[j-1] & j[i]);
    s2_ld = !s2_v_q | out_ready;
    s1_ld = !s1_v_q | s2_ld;
    s2_en = s2_ld & s1_v_q;
    out_hs = s2_v_q & out_ready;
    corr = s1_pe_q & (s1_syn_q <= N_P);
    unc = (s1_pe_q | (s1_syn_q != '0)) & !corr;
    // equality with a nonzero position replaces the old syn-1 shift, so syn=0 never flips anything
    for (int j = 1; j <= N; j++)
      fixed[j-1] = s1_cw_q[j-1] ^ (corr & (s1_syn_q == P'(j)));
    data = '0;
    k = 0;
    for (int j = 1; j <= N; j++)
      if ((j & (j - 1)) != 0) begin
        data[k] = fixed[j-1];
        k = k + 1;
      end
    s1_v_d = s1_ld ? in_valid : s1_v_q;
    s1_cw_d = (s1_ld & in_valid) ? in_cw : s1_cw_q;
    s1_syn_d = (s1_ld & in_valid) ? syn : s1_syn_q;
    s1_pe_d = (s1_ld & in_valid) ? ^in_cw : s1_pe_q;
    s2_v_d = s2_ld ? s1_v_q : s2_v_q;
    s2_data_d = s2_en ? data : s2_data_q;
    s2_syn_d = s2_en ? s1_syn_q : s2_syn_q;
    s2_corr_d = s2_en ? corr : s2_corr_q;
    s2_unc_d = s2_en ? unc : s2_unc_q;
    corr_cnt_d = cnt_clr ? '0 : (out_hs & s2_corr_q & (corr_cnt_q != CNT_MAX)) ? corr_cnt_q + 1'b1 : corr_cnt_q;
    uncorr_cnt_d = cnt_clr ? '0 : (out_hs & s2_unc_q & (uncorr_cnt_q != CNT_MAX)) ? uncorr_cnt_q + 1'b1 : uncorr_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_cw_q <= '0;
      s1_syn_q <= '0;
      s1_pe_q <= 1'b0;
      s2_v_q <= 1'b0;
      s2_data_q <= '0;
      s2_syn_q <= '0;
      s2_corr_q <= 1'b0;
      s2_unc_q <= 1'b0;
      corr_cnt_q <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_cw_q <= s1_cw_d;
      s1_syn_q <= s1_syn_d;
      s1_pe_q <= s1_pe_d;
      s2_v_q <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_syn_q <= s2_syn_d;
      s2_corr_q <= s2_corr_d;
      s2_unc_q <= s2_unc_d;
      corr_cnt_q <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end
  assign in_ready = s1_ld;
  assign out_valid = s2_v_q;
  assign out_data = s2_data_q;
  assign out_syndrome = s2_syn_q;
  assign out_corrected = s2_corr_q;
  assign out_uncorrectable = s2_unc_q;
  assign corr_cnt = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
endmodule
